queue_2x122: RTL and testbench
==============================

QUEUE_2X122 -- requirements
Module: queue_2x122

Interface
REQ-001 SHALL expose parameter WIDTH, 122, payload bit width.
REQ-002 SHALL expose parameter DEPTH, 2, entry count; only 2 supported.
REQ-003 SHALL expose parameter FLOW, 0, 1 = empty-queue combinational bypass enq->deq.
REQ-004 SHALL expose parameter PIPE, 0, 1 = enq_ready also asserted when full and io_deq_ready=1.
REQ-005 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port io_enq_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port io_enq_valid  input  1  producer offers io_enq_bits.
REQ-009 SHALL have port io_enq_bits  input  WIDTH  enqueue payload.
REQ-010 SHALL have port io_deq_ready  input  1  consumer accepts io_deq_bits.
REQ-011 SHALL have port io_deq_valid  output  1  io_deq_bits holds a valid entry.
REQ-012 SHALL have port io_deq_bits  output  WIDTH  head-of-queue payload.
REQ-013 SHALL have port io_count  output  2  occupancy 0..2.

Function
REQ-014 SHALL hold state enq_ptr (1b), deq_ptr (1b), maybe_full (1b); payload stored in a 2xWIDTH memory, write-port clocked, read-port combinational.
REQ-015 SHALL derive ptr_match = (enq_ptr == deq_ptr); empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
REQ-016 SHALL drive io_enq_ready = ~full, OR io_deq_ready when PIPE=1.
REQ-017 SHALL drive io_deq_valid = ~empty, OR io_enq_valid when FLOW=1.
REQ-018 SHALL define do_enq = io_enq_ready & io_enq_valid and do_deq = io_deq_ready & io_deq_valid; when FLOW=1 and empty and io_deq_ready=1, both SHALL be forced 0 (bypass, no state change).
REQ-019 SHALL write io_enq_bits to memory[enq_ptr] on do_enq; enq_ptr SHALL toggle (wrap 1->0) on do_enq.
REQ-020 SHALL toggle deq_ptr (wrap 1->0) on do_deq.
REQ-021 SHALL set maybe_full <= do_enq when do_enq != do_deq; unchanged otherwise (simultaneous enq+deq keeps occupancy).
REQ-022 SHALL drive io_deq_bits = memory[deq_ptr]; when FLOW=1 and empty, io_enq_bits instead; value is don't-care when io_deq_valid=0.
REQ-023 SHALL drive io_count = 2 if full, 0 if empty, 1 otherwise.
REQ-024 SHALL give enq-to-deq latency of 1 cycle (FLOW=0): entry written at edge N is visible with io_deq_valid=1 in cycle N+1.
REQ-025 SHALL, when full and PIPE=0, hold io_enq_ready=0 regardless of io_deq_ready; offered data is not written.
REQ-026 SHALL, when full and PIPE=1 with deq+enq in same cycle, write into the freed slot (enq_ptr == deq_ptr) with occupancy staying 2.
REQ-027 SHALL ignore io_deq_ready when empty (FLOW=0): no pointer movement, io_count stays 0.
REQ-028 SHALL NOT change state on io_enq_valid=1 with io_enq_ready=0.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, set enq_ptr=0, deq_ptr=0, maybe_full=0; reset has priority over do_enq/do_deq in that cycle.
REQ-030 SHALL present after reset: io_enq_ready=1, io_deq_valid=0 (FLOW=0), io_count=0.
REQ-031 SHALL NOT clear memory contents on reset; entries present at reset mid-operation are discarded (never dequeued).
REQ-032 SHALL randomize memory and state registers at simulation start under the standard randomization macros only.

Structure
REQ-033 SHALL place WIDTH/DEPTH defaults and the 2-bit count width constant in shared package queue_pkg.
REQ-034 SHALL instantiate the storage as sub-module ram_2x122 (R0 addr=deq_ptr, en=1; W0 addr=enq_ptr, en=do_enq, data=io_enq_bits; both clocks=clock); all pointer/flag logic lives in queue_2x122.

Verification
REQ-035 SHALL cover: reset, enq 122'h1 then 122'h2 with deq_ready=0 -> count 0,1,2; enq_ready=0 after second; deq yields 122'h1 then 122'h2.
REQ-036 SHALL cover: full, enq_valid=1 bits 122'h3, deq_ready=1, PIPE=0 -> only deq fires, count 2->1, 122'h3 not stored.
REQ-037 SHALL cover: count=1, simultaneous enq 122'hA and deq -> count stays 1, pointers both toggle, next deq yields 122'hA.
REQ-038 SHALL cover: FLOW=1, empty, enq_valid=1 bits 122'h5, deq_ready=1 -> deq_valid=1, deq_bits=122'h5 same cycle, count stays 0.
REQ-039 SHALL cover: full, reset asserted with enq_valid=1 and deq_ready=1 -> next cycle count=0, enq_ready=1, deq_valid=0.
REQ-040 SHALL cover: 10 alternating enq/deq cycles wrapping pointers -> data out in order, count never exceeds 2.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared defaults for the two-entry queue and its storage.
package queue_pkg;
  localparam int QUEUE_WIDTH = 122;
  localparam int QUEUE_DEPTH = 2;
  localparam int COUNT_W     = 2;
endpackage

// File: rtl/ram_2x122.sv
// Two-entry payload store: clocked write port, combinational read port.
module ram_2x122
  import queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic             R0_en,
  input  logic [0:0]       R0_addr,
  output logic [WIDTH-1:0] R0_data,
  input  logic             W0_clk,
  input  logic             W0_en,
  input  logic [0:0]       W0_addr,
  input  logic [WIDTH-1:0] W0_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      mem[W0_addr] <= W0_data;
    end
  end

  // The read side is asynchronous, so it needs no clock of its own.
  assign R0_data = R0_en ? mem[R0_addr] : '0;

`ifdef RANDOMIZE_MEM_INIT
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < WIDTH; b++) begin
        mem[i][b] = 1'($urandom);
      end
    end
  end
`endif

endmodule

// File: rtl/queue_2x122.sv
// Two-entry ready/valid queue with optional empty bypass (FLOW) and
// full-queue pass-through acceptance (PIPE).
module queue_2x122
  import queue_pkg::*;
#(
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               io_enq_ready,
  input  logic               io_enq_valid,
  input  logic [WIDTH-1:0]   io_enq_bits,
  input  logic               io_deq_ready,
  output logic               io_deq_valid,
  output logic [WIDTH-1:0]   io_deq_bits,
  output logic [COUNT_W-1:0] io_count
);

  localparam bit FLOW_EN = (FLOW != 0);
  localparam bit PIPE_EN = (PIPE != 0);

  logic             enq_ptr;
  logic             deq_ptr;
  logic             maybe_full;
  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             do_enq;
  logic             do_deq;
  logic [WIDTH-1:0] ram_data;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  // Handshake: a transfer happens on a side exactly in a cycle where both
  // valid and ready are high; valid never depends on the same side's ready.
  assign io_enq_ready = ~full | (PIPE_EN & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);

  // Bypass hands the producer's word straight to the consumer; storage untouched.
  assign bypass = FLOW_EN & empty & io_deq_ready;
  assign do_enq = io_enq_ready & io_enq_valid & ~bypass;
  assign do_deq = io_deq_ready & io_deq_valid & ~bypass;

  assign io_deq_bits = (FLOW_EN & empty) ? io_enq_bits : ram_data;
  assign io_count    = full ? COUNT_W'(2) : (empty ? COUNT_W'(0) : COUNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= 1'b0;
      deq_ptr    <= 1'b0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr <= ~enq_ptr;
      end
      if (do_deq) begin
        deq_ptr <= ~deq_ptr;
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

`ifdef RANDOMIZE_REG_INIT
  initial begin
    enq_ptr    = 1'($urandom);
    deq_ptr    = 1'($urandom);
    maybe_full = 1'($urandom);
  end
`endif

  ram_2x122 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) ram (
    .R0_en  (1'b1),
    .R0_addr(deq_ptr),
    .R0_data(ram_data),
    .W0_clk (clock),
    .W0_en  (do_enq),
    .W0_addr(enq_ptr),
    .W0_data(io_enq_bits)
  );

endmodule

// File: tb/tb_queue_2x122.sv
// Bench for queue_2x122: a plain instance and a FLOW=1/PIPE=1 instance share
// stimulus; each is checked against its own queue-based reference model.
module tb_queue_2x122;
  import queue_pkg::*;

  localparam int W = QUEUE_WIDTH;
  typedef logic [W-1:0] data_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         enq_valid;
  logic         deq_ready;
  data_t        enq_bits;

  logic         a_enq_ready, a_deq_valid;
  data_t        a_deq_bits;
  logic [1:0]   a_count;
  logic         b_enq_ready, b_deq_valid;
  data_t        b_deq_bits;
  logic [1:0]   b_count;

  data_t exp_q_a[$];
  data_t exp_q_b[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  queue_2x122 #(.FLOW(0), .PIPE(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_enq_ready(a_enq_ready),
    .io_enq_valid(enq_valid),
    .io_enq_bits (enq_bits),
    .io_deq_ready(deq_ready),
    .io_deq_valid(a_deq_valid),
    .io_deq_bits (a_deq_bits),
    .io_count    (a_count)
  );

  queue_2x122 #(.FLOW(1), .PIPE(1)) dut_fp (
    .clock       (clock),
    .reset       (reset),
    .io_enq_ready(b_enq_ready),
    .io_enq_valid(enq_valid),
    .io_enq_bits (enq_bits),
    .io_deq_ready(deq_ready),
    .io_deq_valid(b_deq_valid),
    .io_deq_bits (b_deq_bits),
    .io_count    (b_count)
  );

  // Clock/reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input data_t obs, input data_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict one instance's outputs from its queue contents and the inputs,
  // and report which queue operations the cycle performs.
  task automatic check_side(input string nm, input bit flow, input bit pipe,
                            input int size, input data_t head,
                            input logic er, input logic dv, input data_t db,
                            input logic [1:0] cnt,
                            output bit push, output bit pop);
    logic e_er, e_dv;
    e_er = (size < 2) || (pipe && deq_ready);
    e_dv = (size > 0) || (flow && enq_valid);
    check({nm, ".enq_ready"}, data_t'(er), data_t'(e_er));
    check({nm, ".deq_valid"}, data_t'(dv), data_t'(e_dv));
    if (e_dv) begin
      check({nm, ".deq_bits"}, db, (size > 0) ? head : enq_bits);
    end
    check({nm, ".count"}, data_t'(cnt), data_t'(size));
    pop  = deq_ready && (size > 0);
    push = enq_valid && e_er && !(flow && size == 0 && deq_ready);
  endtask

  // Driver: apply one cycle of inputs, check, advance the models.
  task automatic cycle(input logic ev, input data_t bits, input logic dr, input logic rst);
    bit push_a, pop_a, push_b, pop_b;
    @(negedge clock);
    enq_valid = ev;
    enq_bits  = bits;
    deq_ready = dr;
    reset     = rst;
    #1;
    check_side("plain", 1'b0, 1'b0, exp_q_a.size(), (exp_q_a.size() > 0) ? exp_q_a[0] : '0,
               a_enq_ready, a_deq_valid, a_deq_bits, a_count, push_a, pop_a);
    check_side("flowpipe", 1'b1, 1'b1, exp_q_b.size(), (exp_q_b.size() > 0) ? exp_q_b[0] : '0,
               b_enq_ready, b_deq_valid, b_deq_bits, b_count, push_b, pop_b);
    if (rst) begin
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      if (pop_a) void'(exp_q_a.pop_front());
      if (push_a) exp_q_a.push_back(bits);
      if (pop_b) void'(exp_q_b.pop_front());
      if (push_b) exp_q_b.push_back(bits);
    end
  endtask

  function automatic data_t rand_data();
    return data_t'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    reset     = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_bits  = '0;
    repeat (2) @(posedge clock);

    // Reset state, then fill to two entries with the consumer stalled.
    cycle(1'b0, data_t'(0), 1'b0, 1'b0);
    cycle(1'b1, data_t'(1), 1'b0, 1'b0);
    cycle(1'b1, data_t'(2), 1'b0, 1'b0);
    cycle(1'b0, data_t'(0), 1'b0, 1'b0);
    // Full with enq+deq offered, then simultaneous enq/deq at one entry.
    cycle(1'b1, data_t'(3), 1'b1, 1'b0);
    cycle(1'b1, data_t'('hA), 1'b1, 1'b0);
    repeat (3) cycle(1'b0, data_t'(0), 1'b1, 1'b0);
    // Empty with both sides active: bypass on the FLOW instance.
    cycle(1'b1, data_t'(5), 1'b1, 1'b0);
    cycle(1'b0, data_t'(0), 1'b1, 1'b0);
    // Reset while full with both handshakes offered.
    cycle(1'b1, data_t'(6), 1'b0, 1'b0);
    cycle(1'b1, data_t'(7), 1'b0, 1'b0);
    cycle(1'b1, data_t'(8), 1'b1, 1'b1);
    cycle(1'b0, data_t'(0), 1'b0, 1'b0);
    // Alternating enq/deq wraps both pointers repeatedly.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, data_t'('h10 + i), 1'b0, 1'b0);
      cycle(1'b0, data_t'(0), 1'b1, 1'b0);
    end
    // Random traffic with occasional mid-operation reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
